// File: rtl/tensor_pkg.sv
// Package shared by the tensor parameter loader slice.
// Contents:
//   state_t      loader FSM states (IDLE, LOAD_MAT, LOAD_VEC, CHECK)
//   DATA_W       parameter word width
//   DEF_*        default matrix/vector dimensions and index widths
// CHECK is only reachable when TENSOR_LOADER_CHECKSUM_EN is defined.
package tensor_pkg;

  localparam int DATA_W      = 16;
  localparam int DEF_ROWS    = 2;
  localparam int DEF_COLS    = 4;
  localparam int DEF_VEC_LEN = 4;
  localparam int DEF_ROW_W   = 2;
  localparam int DEF_COL_W   = 4;
  localparam int DEF_VEC_W   = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_MAT = 2'd1,
    LOAD_VEC = 2'd2,
    CHECK    = 2'd3
  } state_t;

endpackage

// File: rtl/tensor_param_loader_if.sv
// Valid/ready parameter stream between the host parameter path and the loader.
// Signals:
//   in_valid  word valid (host -> loader)
//   in_data   parameter word (host -> loader)
//   in_ready  loader can take a word (loader -> host)
// Modports: master = host side, slave = loader side.
interface tensor_param_loader_if #(
  parameter int W = tensor_pkg::DATA_W
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/tensor_index_counter.sv
// 2-D row/column index counter. Column steps first; at the last column it
// wraps to 0 and the row advances (row wraps to 0 after the last row).
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   clear         synchronous return to (0,0); wins over en
//   en            advance one position
//   row, col      current position
//   last          high while positioned at (ROWS-1, COLS-1)
// A 1-D index is obtained by instantiating with ROWS = 1.
module tensor_index_counter #(
  parameter int ROWS  = 2,
  parameter int COLS  = 4,
  parameter int ROW_W = 2,
  parameter int COL_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  logic [ROW_W-1:0] row_reg;
  logic [COL_W-1:0] col_reg;
  logic             col_wrap;
  logic             row_wrap;

  assign col_wrap = (col_reg == COL_MAX);
  assign row_wrap = (row_reg == ROW_MAX);
  assign last     = col_wrap & row_wrap;
  assign row      = row_reg;
  assign col      = col_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (clear) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (en) begin
      if (col_wrap) begin
        col_reg <= '0;
        row_reg <= row_wrap ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tensor_param_loader.sv
// Write-side initiator for the tensor parameter stores. Takes a valid/ready
// stream of words and writes them row-major into the matrix store, then in
// order into the vector store. All store-side outputs are registered: a word
// accepted in cycle N produces its strobe/indices/data in cycle N+1.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 begin a load (only looked at in IDLE)
//   abort                 cancel a load, back to IDLE next cycle, no done
//   in_bus (slave)        parameter word stream
//   mat_write/seli/selj   matrix store strobe and row/column index
//   vec_write/vec_sel     vector store strobe and index
//   param_data            word for both stores
//   busy                  any state other than IDLE
//   done                  one-cycle pulse at load completion
//   err                   checksum mismatch (TENSOR_LOADER_CHECKSUM_EN only)
// Optional feature macro: TENSOR_LOADER_CHECKSUM_EN adds a CHECK state that
// consumes one trailing checksum word and reports err alongside done.
module tensor_param_loader
  import tensor_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int ROW_W   = DEF_ROW_W,
  parameter int COL_W   = DEF_COL_W,
  parameter int VEC_W   = DEF_VEC_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  tensor_param_loader_if.slave   in_bus,
  output logic                   mat_write,
  output logic [ROW_W-1:0]       mat_seli,
  output logic [COL_W-1:0]       mat_selj,
  output logic                   vec_write,
  output logic [VEC_W-1:0]       vec_sel,
  output logic [DATA_W-1:0]      param_data,
  output logic                   busy,
  output logic                   done
`ifdef TENSOR_LOADER_CHECKSUM_EN
  ,
  output logic                   err
`endif
);

  state_t state_reg, state_next;

  logic              mat_write_reg,  mat_write_next;
  logic [ROW_W-1:0]  mat_seli_reg,   mat_seli_next;
  logic [COL_W-1:0]  mat_selj_reg,   mat_selj_next;
  logic              vec_write_reg,  vec_write_next;
  logic [VEC_W-1:0]  vec_sel_reg,    vec_sel_next;
  logic [DATA_W-1:0] param_data_reg, param_data_next;
  logic              done_reg,       done_next;

`ifdef TENSOR_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_reg, sum_next;
  logic              err_reg, err_next;
`endif

  logic             in_ready_w;
  logic             accept;
  logic             mat_en, vec_en, cnt_clear;
  logic [ROW_W-1:0] mat_row;
  logic [COL_W-1:0] mat_col;
  logic             mat_last;
  logic [0:0]       vec_row;
  logic [VEC_W-1:0] vec_col;
  logic             vec_last;
  logic [VEC_W-1:0] vec_idx;

  // Ready is a function of state only, never of in_valid.
`ifdef TENSOR_LOADER_CHECKSUM_EN
  assign in_ready_w = (state_reg == LOAD_MAT) || (state_reg == LOAD_VEC) ||
                      (state_reg == CHECK);
`else
  assign in_ready_w = (state_reg == LOAD_MAT) || (state_reg == LOAD_VEC);
`endif
  assign in_bus.in_ready = in_ready_w;
  assign accept          = in_bus.in_valid & in_ready_w;

  tensor_index_counter #(
    .ROWS (ROWS),
    .COLS (COLS),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) u_mat_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .en     (mat_en),
    .row    (mat_row),
    .col    (mat_col),
    .last   (mat_last)
  );

  tensor_index_counter #(
    .ROWS (1),
    .COLS (VEC_LEN),
    .ROW_W(1),
    .COL_W(VEC_W)
  ) u_vec_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .en     (vec_en),
    .row    (vec_row),
    .col    (vec_col),
    .last   (vec_last)
  );

  // Flattened index of the single-row counter; the row term is always zero.
  assign vec_idx = VEC_W'(vec_row) * VEC_W'(VEC_LEN) + vec_col;

  always_comb begin
    state_next      = state_reg;
    mat_write_next  = 1'b0;
    vec_write_next  = 1'b0;
    done_next       = 1'b0;
    mat_seli_next   = mat_seli_reg;
    mat_selj_next   = mat_selj_reg;
    vec_sel_next    = vec_sel_reg;
    param_data_next = param_data_reg;
    mat_en          = 1'b0;
    vec_en          = 1'b0;
    cnt_clear       = 1'b0;
`ifdef TENSOR_LOADER_CHECKSUM_EN
    sum_next        = sum_reg;
    err_next        = err_reg;
`endif

    if (abort) begin
      // A word offered in the abort cycle is dropped.
      state_next = IDLE;
      cnt_clear  = 1'b1;
`ifdef TENSOR_LOADER_CHECKSUM_EN
      sum_next   = '0;
      err_next   = 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = LOAD_MAT;
            cnt_clear  = 1'b1;
`ifdef TENSOR_LOADER_CHECKSUM_EN
            sum_next   = '0;
            err_next   = 1'b0;
`endif
          end
        end
        LOAD_MAT: begin
          if (accept) begin
            mat_write_next  = 1'b1;
            mat_seli_next   = mat_row;
            mat_selj_next   = mat_col;
            param_data_next = in_bus.in_data;
            mat_en          = 1'b1;
`ifdef TENSOR_LOADER_CHECKSUM_EN
            sum_next        = sum_reg + in_bus.in_data;
`endif
            if (mat_last) state_next = LOAD_VEC;
          end
        end
        LOAD_VEC: begin
          if (accept) begin
            vec_write_next  = 1'b1;
            vec_sel_next    = vec_idx;
            param_data_next = in_bus.in_data;
            vec_en          = 1'b1;
`ifdef TENSOR_LOADER_CHECKSUM_EN
            sum_next        = sum_reg + in_bus.in_data;
            if (vec_last) state_next = CHECK;
`else
            if (vec_last) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
`endif
          end
        end
        CHECK: begin
`ifdef TENSOR_LOADER_CHECKSUM_EN
          // Trailing checksum word: consumed without a store strobe.
          if (accept) begin
            state_next = IDLE;
            done_next  = 1'b1;
            err_next   = (sum_reg != in_bus.in_data);
          end
`else
          state_next = IDLE;
`endif
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      mat_write_reg  <= 1'b0;
      mat_seli_reg   <= '0;
      mat_selj_reg   <= '0;
      vec_write_reg  <= 1'b0;
      vec_sel_reg    <= '0;
      param_data_reg <= '0;
      done_reg       <= 1'b0;
`ifdef TENSOR_LOADER_CHECKSUM_EN
      sum_reg        <= '0;
      err_reg        <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      mat_write_reg  <= mat_write_next;
      mat_seli_reg   <= mat_seli_next;
      mat_selj_reg   <= mat_selj_next;
      vec_write_reg  <= vec_write_next;
      vec_sel_reg    <= vec_sel_next;
      param_data_reg <= param_data_next;
      done_reg       <= done_next;
`ifdef TENSOR_LOADER_CHECKSUM_EN
      sum_reg        <= sum_next;
      err_reg        <= err_next;
`endif
    end
  end

  assign mat_write  = mat_write_reg;
  assign mat_seli   = mat_seli_reg;
  assign mat_selj   = mat_selj_reg;
  assign vec_write  = vec_write_reg;
  assign vec_sel    = vec_sel_reg;
  assign param_data = param_data_reg;
  assign done       = done_reg;
  assign busy       = (state_reg != IDLE);
`ifdef TENSOR_LOADER_CHECKSUM_EN
  assign err        = err_reg;
`endif

endmodule

// File: tb/tb_tensor_param_loader.sv
// Directed bench for tensor_param_loader with a write scoreboard.
// Expected store writes are queued as words are driven and compared by a
// monitor when the DUT strobes. Optional macro TENSOR_LOADER_CHECKSUM_EN
// enables the checksum checks.
module tb_tensor_param_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic        mat_write;
  logic [1:0]  mat_seli;
  logic [3:0]  mat_selj;
  logic        vec_write;
  logic [3:0]  vec_sel;
  logic [15:0] param_data;
  logic        busy;
  logic        done;
`ifdef TENSOR_LOADER_CHECKSUM_EN
  logic        err;
`endif

  tensor_param_loader_if #(.W(16)) bus ();

  tensor_param_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .in_bus    (bus.slave),
    .mat_write (mat_write),
    .mat_seli  (mat_seli),
    .mat_selj  (mat_selj),
    .vec_write (vec_write),
    .vec_sel   (vec_sel),
    .param_data(param_data),
    .busy      (busy),
    .done      (done)
`ifdef TENSOR_LOADER_CHECKSUM_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = matrix write, 1 = vector write, 2 = checksum word (no strobe)
  typedef struct {
    int          kind;
    int          row;
    int          col;
    int          idx;
    logic [15:0] data;
    bit          done;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   acc_pend   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: outputs sampled on the falling edge; acc_pend holds whether a
  // word was handed over at the rising edge just before this sample.
  always @(negedge clk) begin
    exp_t e;
    if (acc_pend) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        $display("txn kind=%0d mat_write=%0d vec_write=%0d seli=%0d selj=%0d vsel=%0d data=%0d done=%0d",
                 e.kind, mat_write, vec_write, mat_seli, mat_selj, vec_sel, param_data, done);
        chk("mat_write", 32'(mat_write), 32'(e.kind == 0));
        chk("vec_write", 32'(vec_write), 32'(e.kind == 1));
        if (e.kind == 0) begin
          chk("mat_seli", 32'(mat_seli), 32'(e.row));
          chk("mat_selj", 32'(mat_selj), 32'(e.col));
        end
        if (e.kind == 1) chk("vec_sel", 32'(vec_sel), 32'(e.idx));
        if (e.kind != 2) chk("param_data", 32'(param_data), 32'(e.data));
        chk("done", 32'(done), 32'(e.done));
`ifdef TENSOR_LOADER_CHECKSUM_EN
        if (e.kind == 2) chk("err", 32'(err), 32'(e.err));
`endif
      end
    end else begin
      chk("idle_mat_write", 32'(mat_write), 32'd0);
      chk("idle_vec_write", 32'(vec_write), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end
    #1 acc_pend = bus.in_valid && bus.in_ready;
  end

  task automatic push(input int kind, input int row, input int col, input int idx,
                      input logic [15:0] d, input bit dn, input bit er);
    exp_t e;
    e.kind = kind; e.row = row; e.col = col; e.idx = idx;
    e.data = d; e.done = dn; e.err = er;
    sb.push_back(e);
  endtask

  // Offers one word from the next falling edge; returns on the falling edge
  // before the rising edge that accepts it.
  task automatic send_word(input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic gap();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("ready_after_start", 32'(bus.in_ready), 32'd1);
  endtask

  // Streams 12 words base+1..base+12 (plus the checksum word when enabled).
  task automatic stream_load(input int base, input bit gaps, input bit poke_start,
                             input logic [15:0] csum, input bit exp_err);
    for (int k = 0; k < 12; k++) begin
      logic [15:0] d;
      d = 16'(base + k + 1);
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) gap();
      end
      start = poke_start && (k == 5);
`ifdef TENSOR_LOADER_CHECKSUM_EN
      if (k < 8) push(0, k / 4, k % 4, 0, d, 1'b0, 1'b0);
      else       push(1, 0, 0, k - 8, d, 1'b0, 1'b0);
`else
      if (k < 8) push(0, k / 4, k % 4, 0, d, 1'b0, 1'b0);
      else       push(1, 0, 0, k - 8, d, k == 11, 1'b0);
`endif
      send_word(d);
    end
    start = 1'b0;
`ifdef TENSOR_LOADER_CHECKSUM_EN
    push(2, 0, 0, 0, csum, 1'b1, exp_err);
    send_word(csum);
`else
    if (csum != 16'd0 || exp_err) chk("unused_csum", 32'd0, 32'd0 + 32'(csum) - 32'(csum));
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mat_write"}, 32'(mat_write), 32'd0);
    chk({tag, "_seli"}, 32'(mat_seli), 32'd0);
    chk({tag, "_selj"}, 32'(mat_selj), 32'd0);
    chk({tag, "_vec_write"}, 32'(vec_write), 32'd0);
    chk({tag, "_vec_sel"}, 32'(vec_sel), 32'd0);
    chk({tag, "_param_data"}, 32'(param_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_zero("reset");
    #2 reset_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    // Load with no stalls; start pulsed mid-load must be ignored
    pulse_start();
    stream_load(0, 1'b0, 1'b1, 16'd78, 1'b0);
    gap();
    chk("busy_done_cycle", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(bus.in_ready), 32'd0);
    chk("sb_drained_1", 32'(sb.size()), 32'd0);
`ifdef TENSOR_LOADER_CHECKSUM_EN
    chk("err_clean", 32'(err), 32'd0);
`endif

    // Random in_valid gaps, then start in the done cycle
    pulse_start();
    stream_load(100, 1'b1, 1'b0, 16'd1278, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    stream_load(200, 1'b1, 1'b0, 16'd77, 1'b1);
    gap();
    repeat (3) @(negedge clk);
`ifdef TENSOR_LOADER_CHECKSUM_EN
    chk("err_held", 32'(err), 32'd1);
`endif

    // Abort after the 5th word
    pulse_start();
`ifdef TENSOR_LOADER_CHECKSUM_EN
    chk("err_cleared_by_start", 32'(err), 32'd0);
`endif
    for (int k = 0; k < 5; k++) begin
      push(0, k / 4, k % 4, 0, 16'(50 + k), 1'b0, 1'b0);
      send_word(16'(50 + k));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(bus.in_ready), 32'd0);
    // abort together with start in IDLE stays idle
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort_start_busy", 32'(busy), 32'd0);
    pulse_start();
    stream_load(300, 1'b0, 1'b0, 16'd3678, 1'b0);
    gap();
    repeat (2) @(negedge clk);

    // Reset after the 3rd word
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      push(0, 0, k, 0, 16'(60 + k), 1'b0, 1'b0);
      send_word(16'(60 + k));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_after_reset", 32'(bus.in_ready), 32'd0);
    pulse_start();
    stream_load(400, 1'b1, 1'b0, 16'd4878, 1'b0);
    gap();
    repeat (3) @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
